// File: rtl/reg_read_stage.sv
// -----------------------------------------------------------------------------
// reg_read_stage
//
// Register-read stage between the issue unit and an execution unit. It drives
// the physical register file read addresses straight from the issuing
// instruction's source indices, selects each operand (hard zero for index 0,
// otherwise a same-cycle CDB broadcast or the register file value), and
// captures operands plus the opaque payload in a single output register that
// follows a valid/ready handshake toward the execution unit.
//
// Configuration macro: RR_CDB_BYPASS_EN
//   defined   - a CDB broadcast whose destination matches a nonzero source
//               index in the accept cycle is forwarded into the operand.
//   undefined - no forwarding muxes; instead the stage refuses an instruction
//               whose nonzero source is being broadcast this cycle, so it is
//               taken a cycle later once the register file holds the value.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   flush             kills the held instruction and refuses the incoming one
//   iss_valid/ready   issue handshake
//   iss_prs1_s/2_s    physical source indices
//   iss_payload       opaque payload carried to the execution unit
//   prf_prs1_s/2_s    register file read addresses (combinational)
//   prf_prs1_v/2_v    register file read data (combinational)
//   cdb_bc            per-lane broadcast valid
//   cdb_prd_s         per-lane destination index
//   cdb_prd_v         per-lane result value
//   eu_valid/ready    execution unit handshake
//   eu_rs1_v/rs2_v    registered source operands
//   eu_payload        registered payload
// -----------------------------------------------------------------------------
module reg_read_stage #(
    parameter int PRF_IDX_W = 6,
    parameter int CDB_WIDTH = 2,
    parameter int PAYLOAD_W = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,

    input  logic                                 iss_valid,
    output logic                                 iss_ready,
    input  logic [PRF_IDX_W-1:0]                 iss_prs1_s,
    input  logic [PRF_IDX_W-1:0]                 iss_prs2_s,
    input  logic [PAYLOAD_W-1:0]                 iss_payload,

    output logic [PRF_IDX_W-1:0]                 prf_prs1_s,
    output logic [PRF_IDX_W-1:0]                 prf_prs2_s,
    input  logic [31:0]                          prf_prs1_v,
    input  logic [31:0]                          prf_prs2_v,

    input  logic [CDB_WIDTH-1:0]                 cdb_bc,
    input  logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0]  cdb_prd_s,
    input  logic [CDB_WIDTH-1:0][31:0]           cdb_prd_v,

    output logic                                 eu_valid,
    input  logic                                 eu_ready,
    output logic [31:0]                          eu_rs1_v,
    output logic [31:0]                          eu_rs2_v,
    output logic [PAYLOAD_W-1:0]                 eu_payload
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic                 valid_q, valid_d;
    logic [31:0]          rs1_q, rs1_d;
    logic [31:0]          rs2_q, rs2_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;

    // High for the first cycle after reset: register file read data is not
    // trustworthy yet, so nothing may be accepted.
    logic                 blk_q;

    logic                 ready_base;
    logic                 accept;
    logic [31:0]          rs1_sel;
    logic [31:0]          rs2_sel;

    // Read addresses come straight from the issuing instruction.
    assign prf_prs1_s = iss_prs1_s;
    assign prf_prs2_s = iss_prs2_s;

    // The output register can take a new entry when it is empty or draining.
    assign ready_base = !rst && !flush && !blk_q && (!valid_q || eu_ready);

`ifdef RR_CDB_BYPASS_EN
    // -------------------------------------------------------------------------
    // Operand select with CDB forwarding. Lowest-numbered matching lane wins;
    // index 0 is the hardwired zero register and is never forwarded.
    // -------------------------------------------------------------------------
    function automatic logic [31:0] sel_operand(
        input logic [PRF_IDX_W-1:0]                idx,
        input logic [31:0]                         prf_v,
        input logic [CDB_WIDTH-1:0]                bc,
        input logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0] prd_s,
        input logic [CDB_WIDTH-1:0][31:0]          prd_v
    );
        logic [31:0] v;
        logic        hit;
        v   = prf_v;
        hit = 1'b0;
        for (int i = 0; i < CDB_WIDTH; i++) begin
            if (!hit && bc[i] && (prd_s[i] == idx)) begin
                v   = prd_v[i];
                hit = 1'b1;
            end
        end
        if (idx == '0) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        rs1_sel   = sel_operand(iss_prs1_s, prf_prs1_v, cdb_bc, cdb_prd_s, cdb_prd_v);
        rs2_sel   = sel_operand(iss_prs2_s, prf_prs2_v, cdb_bc, cdb_prd_s, cdb_prd_v);
        iss_ready = ready_base;
    end
`else
    // -------------------------------------------------------------------------
    // No forwarding: an instruction whose nonzero source is on the CDB this
    // cycle would read a stale register file value, so it is held off one
    // cycle until the write has landed.
    // -------------------------------------------------------------------------
    function automatic logic src_on_cdb(
        input logic [PRF_IDX_W-1:0]                idx,
        input logic [CDB_WIDTH-1:0]                bc,
        input logic [CDB_WIDTH-1:0][PRF_IDX_W-1:0] prd_s
    );
        logic h;
        h = 1'b0;
        for (int i = 0; i < CDB_WIDTH; i++) begin
            if (bc[i] && (prd_s[i] == idx)) begin
                h = 1'b1;
            end
        end
        return h && (idx != '0);
    endfunction

    logic cdb_hazard;
    logic unused_cdb_v;

    // Broadcast values are only consumed through the register file here.
    assign unused_cdb_v = ^cdb_prd_v;

    always_comb begin
        rs1_sel    = (iss_prs1_s == '0) ? 32'd0 : prf_prs1_v;
        rs2_sel    = (iss_prs2_s == '0) ? 32'd0 : prf_prs2_v;
        cdb_hazard = iss_valid &&
                     (src_on_cdb(iss_prs1_s, cdb_bc, cdb_prd_s) ||
                      src_on_cdb(iss_prs2_s, cdb_bc, cdb_prd_s));
        iss_ready  = ready_base && !cdb_hazard;
    end
`endif

    assign accept = iss_valid && iss_ready;

    // -------------------------------------------------------------------------
    // Output register next state. Flush dominates; iss_ready is already low
    // during flush so accept cannot fire alongside it.
    // -------------------------------------------------------------------------
    always_comb begin
        valid_d   = valid_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        payload_d = payload_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            rs1_d     = rs1_sel;
            rs2_d     = rs2_sel;
            payload_d = iss_payload;
        end else if (eu_ready) begin
            valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Output register (iss_* -> eu_* always crosses this boundary)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            payload_q <= '0;
            blk_q     <= 1'b1;
        end else begin
            valid_q   <= valid_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            payload_q <= payload_d;
            blk_q     <= 1'b0;
        end
    end

    assign eu_valid   = valid_q;
    assign eu_rs1_v   = rs1_q;
    assign eu_rs2_v   = rs2_q;
    assign eu_payload = payload_q;

endmodule

// File: tb/tb_reg_read_stage.sv
module tb_reg_read_stage;

    localparam int IW = 6;
    localparam int CW = 2;
    localparam int PW = 64;

    logic                     clk = 1'b0;
    logic                     rst, flush;
    logic                     iss_valid, iss_ready;
    logic [IW-1:0]            iss_prs1_s, iss_prs2_s;
    logic [PW-1:0]            iss_payload;
    logic [IW-1:0]            prf_prs1_s, prf_prs2_s;
    logic [31:0]              prf_prs1_v, prf_prs2_v;
    logic [CW-1:0]            cdb_bc;
    logic [CW-1:0][IW-1:0]    cdb_prd_s;
    logic [CW-1:0][31:0]      cdb_prd_v;
    logic                     eu_valid, eu_ready;
    logic [31:0]              eu_rs1_v, eu_rs2_v;
    logic [PW-1:0]            eu_payload;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0]   rs1;
        logic [31:0]   rs2;
        logic [PW-1:0] pay;
    } ent_t;

    ent_t sb[$];
    bit   mon_en  = 1'b0;
    bit   m_valid = 1'b0;
    bit   m_blk   = 1'b1;

    reg_read_stage #(.PRF_IDX_W(IW), .CDB_WIDTH(CW), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_prs1_s(iss_prs1_s), .iss_prs2_s(iss_prs2_s), .iss_payload(iss_payload),
        .prf_prs1_s(prf_prs1_s), .prf_prs2_s(prf_prs2_s),
        .prf_prs1_v(prf_prs1_v), .prf_prs2_v(prf_prs2_v),
        .cdb_bc(cdb_bc), .cdb_prd_s(cdb_prd_s), .cdb_prd_v(cdb_prd_v),
        .eu_valid(eu_valid), .eu_ready(eu_ready),
        .eu_rs1_v(eu_rs1_v), .eu_rs2_v(eu_rs2_v), .eu_payload(eu_payload)
    );

    always #5 clk = ~clk;

    // Reference operand value for a source index given the current inputs.
    function automatic logic [31:0] ref_op(input logic [IW-1:0] idx, input logic [31:0] prf);
        if (idx == 0) return 32'd0;
`ifdef RR_CDB_BYPASS_EN
        for (int i = 0; i < CW; i++)
            if (cdb_bc[i] && cdb_prd_s[i] == idx) return cdb_prd_v[i];
`endif
        return prf;
    endfunction

    function automatic bit ref_hazard();
        bit h = 1'b0;
`ifndef RR_CDB_BYPASS_EN
        for (int i = 0; i < CW; i++) begin
            if (cdb_bc[i] && iss_prs1_s != 0 && cdb_prd_s[i] == iss_prs1_s) h = 1'b1;
            if (cdb_bc[i] && iss_prs2_s != 0 && cdb_prd_s[i] == iss_prs2_s) h = 1'b1;
        end
        h = h && iss_valid;
`endif
        return h;
    endfunction

    // Scoreboard monitor: samples on the falling edge, compares the held entry
    // and iss_ready against the reference, then advances the reference.
    always @(negedge clk) begin
        if (mon_en) begin
            bit   exp_rdy;
            ent_t e;
            checks++;
            if (eu_valid !== m_valid) begin
                errors++;
                $display("FAIL sb_valid t=%0t got=%b exp=%b", $time, eu_valid, m_valid);
            end
            if (m_valid && sb.size() > 0) begin
                checks++;
                if (eu_rs1_v !== sb[0].rs1 || eu_rs2_v !== sb[0].rs2 || eu_payload !== sb[0].pay) begin
                    errors++;
                    $display("FAIL sb_data t=%0t got=%h/%h/%h exp=%h/%h/%h", $time,
                             eu_rs1_v, eu_rs2_v, eu_payload, sb[0].rs1, sb[0].rs2, sb[0].pay);
                end
            end
            exp_rdy = !rst && !flush && !m_blk && (!m_valid || eu_ready) && !ref_hazard();
            checks++;
            if (iss_ready !== exp_rdy) begin
                errors++;
                $display("FAIL sb_ready t=%0t got=%b exp=%b", $time, iss_ready, exp_rdy);
            end
            if (rst) begin
                sb.delete();
                m_valid = 1'b0;
            end else if (flush) begin
                if (m_valid && sb.size() > 0) void'(sb.pop_front());
                m_valid = 1'b0;
            end else begin
                if (m_valid && eu_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    m_valid = 1'b0;
                end
                if (iss_valid && exp_rdy) begin
                    e.rs1 = ref_op(iss_prs1_s, prf_prs1_v);
                    e.rs2 = ref_op(iss_prs2_s, prf_prs2_v);
                    e.pay = iss_payload;
                    sb.push_back(e);
                    m_valid = 1'b1;
                end
            end
            m_blk = rst;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_iss(input logic v, input logic [IW-1:0] s1, input logic [IW-1:0] s2,
                           input logic [31:0] p1, input logic [31:0] p2, input logic [PW-1:0] pay);
        iss_valid = v; iss_prs1_s = s1; iss_prs2_s = s2;
        prf_prs1_v = p1; prf_prs2_v = p2; iss_payload = pay;
    endtask

    task automatic drain();
        iss_valid = 1'b0; eu_ready = 1'b1; cdb_bc = '0; flush = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; eu_ready = 1'b0; cdb_bc = '0;
        cdb_prd_s = '0; cdb_prd_v = '0;
        set_iss(1'b1, 6'd1, 6'd2, 32'h5, 32'h6, 64'h1);
        cyc(); cyc(); #1;
        checks++;
        if (eu_valid !== 1'b0 || eu_rs1_v !== 32'd0 || eu_rs2_v !== 32'd0 || eu_payload !== 64'd0) begin
            errors++;
            $display("FAIL reset_regs got=%b/%h/%h/%h exp=0/0/0/0", eu_valid, eu_rs1_v, eu_rs2_v, eu_payload);
        end
        checks++;
        if (iss_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got=%b exp=0", iss_ready);
        end
        m_valid = 1'b0; m_blk = 1'b1; mon_en = 1'b1;
    endtask

    task automatic test_startup();
        rst = 1'b0; eu_ready = 1'b1;
        set_iss(1'b1, 6'd4, 6'd9, 32'hDEAD, 32'hDEAD, 64'hA1);
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin errors++; $display("FAIL startup_first got=%b exp=0", iss_ready); end
        cyc(); #1;
        checks++;
        if (iss_ready !== 1'b1) begin errors++; $display("FAIL startup_second got=%b exp=1", iss_ready); end
        cyc(); iss_valid = 1'b0; #1;
        checks++;
        if (eu_valid !== 1'b1 || eu_rs1_v !== 32'hDEAD) begin
            errors++; $display("FAIL startup_out got=%b/%h exp=1/0000dead", eu_valid, eu_rs1_v);
        end
        drain();
    endtask

    task automatic test_basic();
        set_iss(1'b1, 6'd5, 6'd0, 32'h11, 32'h77, 64'hB2);
        #1;
        checks++;
        if (prf_prs1_s !== 6'd5 || prf_prs2_s !== 6'd0 || iss_ready !== 1'b1) begin
            errors++; $display("FAIL basic_addr got=%0d/%0d/%b exp=5/0/1", prf_prs1_s, prf_prs2_s, iss_ready);
        end
        cyc(); iss_valid = 1'b0; #1;
        checks++;
        if (eu_valid !== 1'b1 || eu_rs1_v !== 32'h11 || eu_rs2_v !== 32'h0) begin
            errors++; $display("FAIL basic_out got=%b/%h/%h exp=1/11/0", eu_valid, eu_rs1_v, eu_rs2_v);
        end
        cyc(); #1;
        checks++;
        if (eu_valid !== 1'b0) begin errors++; $display("FAIL basic_once got=%b exp=0", eu_valid); end
        drain();
    endtask

    task automatic test_cdb();
        set_iss(1'b1, 6'd7, 6'd2, 32'h0, 32'h22, 64'hC3);
        cdb_bc = 2'b10; cdb_prd_s[1] = 6'd7; cdb_prd_v[1] = 32'hABCD;
        cdb_prd_s[0] = 6'd7; cdb_prd_v[0] = 32'h9999;
        #1;
`ifdef RR_CDB_BYPASS_EN
        checks++;
        if (iss_ready !== 1'b1) begin errors++; $display("FAIL cdb_ready got=%b exp=1", iss_ready); end
`else
        checks++;
        if (iss_ready !== 1'b0) begin errors++; $display("FAIL cdb_stall got=%b exp=0", iss_ready); end
        cyc(); cdb_bc = '0; prf_prs1_v = 32'hABCD; #1;
        checks++;
        if (iss_ready !== 1'b1) begin errors++; $display("FAIL cdb_retry got=%b exp=1", iss_ready); end
`endif
        cyc(); iss_valid = 1'b0; cdb_bc = '0; #1;
        checks++;
        if (eu_valid !== 1'b1 || eu_rs1_v !== 32'hABCD || eu_rs2_v !== 32'h22) begin
            errors++; $display("FAIL cdb_out got=%b/%h/%h exp=1/abcd/22", eu_valid, eu_rs1_v, eu_rs2_v);
        end
        drain();
    endtask

    task automatic test_priority();
        set_iss(1'b1, 6'd6, 6'd3, 32'h66, 32'h33, 64'hD4);
        cdb_bc = 2'b11; cdb_prd_s[0] = 6'd3; cdb_prd_s[1] = 6'd3;
        cdb_prd_v[0] = 32'h1; cdb_prd_v[1] = 32'h2;
`ifndef RR_CDB_BYPASS_EN
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin errors++; $display("FAIL prio_stall got=%b exp=0", iss_ready); end
        cyc(); cdb_bc = '0; prf_prs2_v = 32'h1;
`endif
        cyc(); cdb_bc = '0; #1;
        checks++;
        if (eu_rs2_v !== 32'h1 || eu_rs1_v !== 32'h66) begin
            errors++; $display("FAIL prio_lane got=%h/%h exp=66/1", eu_rs1_v, eu_rs2_v);
        end
        // Zero register must ignore a broadcast targeting index 0.
        set_iss(1'b1, 6'd0, 6'd4, 32'h99, 32'h44, 64'hD5);
        cdb_bc = 2'b01; cdb_prd_s[0] = 6'd0; cdb_prd_v[0] = 32'h55;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got=%b exp=1", iss_ready); end
        cyc(); iss_valid = 1'b0; cdb_bc = '0; #1;
        checks++;
        if (eu_rs1_v !== 32'h0 || eu_rs2_v !== 32'h44) begin
            errors++; $display("FAIL zero_reg got=%h/%h exp=0/44", eu_rs1_v, eu_rs2_v);
        end
        drain();
    endtask

    task automatic test_stall_back_to_back();
        eu_ready = 1'b0;
        set_iss(1'b1, 6'd10, 6'd11, 32'hC1, 32'hC2, 64'hE6);
        cyc();
        set_iss(1'b1, 6'd12, 6'd13, 32'hD1, 32'hD2, 64'hE7);
        cdb_bc = 2'b11; cdb_prd_s[0] = 6'd10; cdb_prd_s[1] = 6'd11;
        cdb_prd_v[0] = 32'hBAD0; cdb_prd_v[1] = 32'hBAD1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (iss_ready !== 1'b0 || eu_valid !== 1'b1 || eu_rs1_v !== 32'hC1 ||
                eu_rs2_v !== 32'hC2 || eu_payload !== 64'hE6) begin
                errors++;
                $display("FAIL stall_hold c=%0d got=%b/%b/%h/%h exp=0/1/c1/c2", i, iss_ready, eu_valid, eu_rs1_v, eu_rs2_v);
            end
            cyc();
        end
        eu_ready = 1'b1; cdb_bc = '0; #1;
        checks++;
        if (iss_ready !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", iss_ready); end
        cyc();
        set_iss(1'b1, 6'd14, 6'd15, 32'hE1, 32'hE2, 64'hE8);
        #1;
        checks++;
        if (eu_valid !== 1'b1 || eu_rs1_v !== 32'hD1) begin
            errors++; $display("FAIL b2b_first got=%b/%h exp=1/d1", eu_valid, eu_rs1_v);
        end
        cyc(); iss_valid = 1'b0; #1;
        checks++;
        if (eu_valid !== 1'b1 || eu_rs1_v !== 32'hE1) begin
            errors++; $display("FAIL b2b_second got=%b/%h exp=1/e1", eu_valid, eu_rs1_v);
        end
        drain();
    endtask

    task automatic test_flush();
        eu_ready = 1'b0;
        set_iss(1'b1, 6'd20, 6'd21, 32'hF1, 32'hF2, 64'hF9);
        cyc();
        set_iss(1'b1, 6'd22, 6'd23, 32'hF3, 32'hF4, 64'hFA);
        flush = 1'b1; #1;
        checks++;
        if (iss_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", iss_ready); end
        cyc(); flush = 1'b0; iss_valid = 1'b0; #1;
        checks++;
        if (eu_valid !== 1'b0) begin errors++; $display("FAIL flush_kill got=%b exp=0", eu_valid); end
        drain();
    endtask

    task automatic test_reset_held();
        eu_ready = 1'b0;
        set_iss(1'b1, 6'd30, 6'd31, 32'h31, 32'h32, 64'hFB);
        cyc();
        rst = 1'b1; cyc();
        rst = 1'b0; iss_valid = 1'b1; #1;
        checks++;
        if (eu_valid !== 1'b0 || eu_payload !== 64'd0 || iss_ready !== 1'b0) begin
            errors++; $display("FAIL rst_held got=%b/%h/%b exp=0/0/0", eu_valid, eu_payload, iss_ready);
        end
        iss_valid = 1'b0;
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_iss($urandom_range(0, 3) != 0, IW'($urandom_range(0, 7)), IW'($urandom_range(0, 7)),
                    $urandom, $urandom, {$urandom, $urandom});
            eu_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 15) == 0;
            cdb_bc = CW'($urandom_range(0, 3));
            for (int l = 0; l < CW; l++) begin
                cdb_prd_s[l] = IW'($urandom_range(0, 7));
                cdb_prd_v[l] = $urandom;
            end
            cyc();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_startup();
        test_basic();
        test_cdb();
        test_priority();
        test_stall_back_to_back();
        test_flush();
        test_reset_held();
        test_random();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_empty got=%0d exp=0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
